// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a shared register written by three requesters.
// One write is in flight at a time: IDLE -> GRANT -> COMMIT -> IDLE.
module shared_reg_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [2:0]       gnt,
  output logic [2:0]       ack,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic [1:0]       last,
  output logic [1:0]       fsm_state
);

  // Handshake: a requester holds req[i] and its data stable until it sees ack[i];
  // gnt[i] marks ownership for two cycles, ack[i] pulses once when q holds its data.
  // Dropping req[i] while only gnt[i] is high abandons the write without an ack.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       sel;
  logic [1:0]       start;
  logic [1:0]       winner;
  logic             sel_req;
  logic [WIDTH-1:0] sel_d;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Search starts one past the last completed writer and wraps; only used when req != 0.
  always_comb begin
    start  = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    winner = start;
    case (start)
      2'd0:    winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      2'd1:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      default: winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
    endcase
  end

  always_comb begin
    sel_req = 1'b0;
    sel_d   = q;
    case (sel)
      2'd0:    begin sel_req = req[0]; sel_d = d0; end
      2'd1:    begin sel_req = req[1]; sel_d = d1; end
      2'd2:    begin sel_req = req[2]; sel_d = d2; end
      default: begin sel_req = 1'b0;   sel_d = q;  end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 2'd0;
      last  <= 2'd2;
      q     <= '0;
      gnt   <= 3'b000;
      ack   <= 3'b000;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 3'b000;
          if (|req) begin
            sel   <= winner;
            state <= GRANT;
            gnt   <= onehot(winner);
            busy  <= 1'b1;
          end else begin
            gnt  <= 3'b000;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          if (sel_req) begin
            q     <= sel_d;
            state <= COMMIT;
            ack   <= onehot(sel);
          end else begin
            state <= IDLE;
            gnt   <= 3'b000;
            ack   <= 3'b000;
            busy  <= 1'b0;
          end
        end
        COMMIT: begin
          last  <= sel;
          state <= IDLE;
          gnt   <= 3'b000;
          ack   <= 3'b000;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= 3'b000;
          ack   <= 3'b000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus protocol-respecting random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_shared_reg_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   req;
  logic [W-1:0] d [3];
  logic [2:0]   gnt;
  logic [2:0]   ack;
  logic [W-1:0] q;
  logic         busy;
  logic [1:0]   last;
  logic [1:0]   fsm_state;

  shared_reg_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .d0(d[0]), .d1(d[1]), .d2(d[2]),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy), .last(last),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: a write moves through phase 0 (free), 1 (owner chosen), 2 (data captured).
  int           m_phase;
  int           m_sel;
  int           m_last;
  logic [W-1:0] m_q;
  logic [W-1:0] exp_q [$];
  int           ack_log [$];
  int           ack_cyc [$];
  logic [W-1:0] q_log [$];
  int           cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2:0] exp_gnt();
    logic [2:0] one;
    one = 3'b001 << m_sel;
    return (m_phase != 0) ? one : 3'b000;
  endfunction

  function automatic logic [2:0] exp_ack();
    logic [2:0] one;
    one = 3'b001 << m_sel;
    return (m_phase == 2) ? one : 3'b000;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_sel   = 0;
    m_last  = 2;
    m_q     = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    case (m_phase)
      0: if (req != 3'b000) begin
        for (int k = 2; k >= 0; k--) begin
          if (req[(m_last + 1 + k) % 3]) m_sel = (m_last + 1 + k) % 3;
        end
        m_phase = 1;
      end
      1: if (req[m_sel]) begin
        m_q = d[m_sel];
        exp_q.push_back(m_q);
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
      default: begin
        m_last  = m_sel;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), 32'(exp_gnt()));
    check("ack", 32'(ack), 32'(exp_ack()));
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("last", 32'(last), 32'(m_last));
    if (ack !== 3'b000) begin
      check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_q", 32'(q), 32'(exp_q.pop_front()));
      for (int i = 0; i < 3; i++) if (ack[i]) ack_log.push_back(i);
      ack_cyc.push_back(cyc);
      q_log.push_back(q);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last", 32'(last), 32'd2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_random();
    logic [2:0] ea;
    ea = exp_ack();
    for (int i = 0; i < 3; i++) begin
      if (req[i]) begin
        if (ea[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else d[i] = W'($urandom_range(15, 0));
        end else if (m_phase == 1 && m_sel == i && $urandom_range(7, 0) == 0) begin
          req[i] = 1'b0;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        req[i] = 1'b1;
        d[i]   = W'($urandom_range(15, 0));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    for (int i = 0; i < 3; i++) d[i] = '0;
    @(negedge clk);

    // Reset with random inputs, then idle cycles.
    req = 3'($urandom_range(7, 0));
    for (int i = 0; i < 3; i++) d[i] = W'($urandom_range(15, 0));
    do_reset();
    req = 3'b000;
    for (int i = 0; i < 5; i++) step();

    // Single write from requester 1.
    req = 3'b010; d[1] = 4'hA;
    step();
    check("single_gnt1", 32'(gnt), 32'b010);
    step();
    check("single_gnt2", 32'(gnt), 32'b010);
    check("single_ack", 32'(ack), 32'b010);
    check("single_q", 32'(q), 32'hA);
    req = 3'b000;
    step();
    check("single_ack_off", 32'(ack), 32'd0);
    check("single_last", 32'(last), 32'd1);

    // Continuous contention from reset.
    do_reset();
    req = 3'b111; d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3;
    ack_log.delete(); ack_cyc.delete(); q_log.delete();
    for (int i = 0; i < 12; i++) step();
    check("cont_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      check("cont_ord0", 32'(ack_log[0]), 32'd0);
      check("cont_ord1", 32'(ack_log[1]), 32'd1);
      check("cont_ord2", 32'(ack_log[2]), 32'd2);
      check("cont_ord3", 32'(ack_log[3]), 32'd0);
      check("cont_q0", 32'(q_log[0]), 32'h1);
      check("cont_q1", 32'(q_log[1]), 32'h2);
      check("cont_q2", 32'(q_log[2]), 32'h3);
      check("cont_q3", 32'(q_log[3]), 32'h1);
      for (int i = 0; i < 3; i++) check("cont_gap", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd3);
    end

    // Rotation after requester 2 writes.
    do_reset();
    req = 3'b100; d[2] = 4'h5;
    for (int i = 0; i < 3; i++) step();
    check("rot_last2", 32'(last), 32'd2);
    req = 3'b101; d[0] = 4'h6;
    ack_log.delete();
    for (int i = 0; i < 6; i++) step();
    check("rot_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check("rot_first", 32'(ack_log[0]), 32'd0);
      check("rot_second", 32'(ack_log[1]), 32'd2);
    end
    req = 3'b000;
    step();

    // Abandon: drop req0 while granted.
    req = 3'b001; d[0] = 4'h7;
    step();
    check("abn_gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    step();
    check("abn_busy", 32'(busy), 32'd0);
    check("abn_ack", 32'(ack), 32'd0);
    check("abn_q", 32'(q), 32'h5);
    check("abn_last", 32'(last), 32'd2);
    step();

    // Asynchronous reset during COMMIT.
    req = 3'b100; d[2] = 4'hF;
    step();
    step();
    check("mid_ack_before", 32'(ack), 32'b100);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_ack", 32'(ack), 32'd0);
    check("mid_gnt", 32'(gnt), 32'd0);
    check("mid_q", 32'(q), 32'd0);
    check("mid_last", 32'(last), 32'd2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("mid_regnt", 32'(gnt), 32'b100);
    step();
    check("mid_reack", 32'(q), 32'hF);
    req = 3'b000;
    step();

    // Random traffic respecting the requester protocol.
    do_reset();
    req = 3'b000;
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and write sequencer for the shared 4-bit D-register. Three requesters compete for the single register. The block grants one requester at a time, captures that requester's data into the register, and returns a one-cycle acknowledge. It sits between the requesting FSMs and the register bank, so the register is never written by two sources in the same cycle.

## Interface
- WIDTH, 4, data width of the shared register and of each requester data bus
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  3  request lines; bit i is requester i; level-sensitive
- d0  input  WIDTH  write data from requester 0
- d1  input  WIDTH  write data from requester 1
- d2  input  WIDTH  write data from requester 2
- gnt  output  3  one-hot grant; at most one bit high
- ack  output  3  one-hot, one-cycle pulse when the write has committed
- q  output  WIDTH  shared register contents
- busy  output  1  high when the FSM is not in IDLE
- last  output  2  index of the most recent requester that completed a write

## Operation
- FSM states are IDLE, GRANT and COMMIT. Outputs are Moore, decoded from registered state and the registered winner index `sel`.
- **IDLE**
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner by round-robin. Priority order starts at (last+1) mod 3 and wraps.
  - Register the winner in `sel` and go to GRANT.
- **GRANT**
  - gnt[sel]=1.
  - If req[sel] is still high at the edge, set q <= d[sel] and go to COMMIT.
  - If req[sel] has dropped (abandon), q is unchanged, last is unchanged, and the FSM goes to IDLE. No ack is issued.
- **COMMIT**
  - gnt[sel]=1 and ack[sel]=1.
  - Unconditionally go to IDLE and set last <= sel.
- Requester protocol:
  - Hold req and d stable from assertion until ack is seen.
  - Drop req the cycle after ack, or keep it high to queue another write.
- A request still high in IDLE is arbitrated as a new request. Rotation guarantees that no requester waits more than 2 other writes.
- req changes during GRANT or COMMIT for non-selected requesters are ignored until the next IDLE.
- sel value 3 is unreachable. If it is ever decoded, drive gnt=0 and ack=0.
- Reset values: state=IDLE, gnt=0, ack=0, q=0, busy=0, sel=0, last=2. With last=2, requester 0 has highest priority after reset.
- Reset asserted mid-operation (GRANT or COMMIT) aborts immediately:
  - No ack is issued.
  - q returns to 0.
  - Any write already committed to q is lost.

## Timing
- Edge E0: FSM is in IDLE and samples req ≠ 0 → state=GRANT.
- Cycle after E0: gnt high, busy high.
- Edge E1: q is loaded.
- Cycle after E1: the new q value is visible, ack is high, gnt is still high.
- Edge E2: FSM returns to IDLE. gnt, ack and busy go low, last updates.
- Latency from the req-sampling edge to q updated is 2 edges. gnt lasts 2 cycles and ack lasts 1 cycle.
- Maximum throughput is one write per 3 cycles. The IDLE cycle between writes is mandatory, even with requests pending.
- Abandon path: GRANT lasts 1 cycle, then IDLE. Total busy time is 1 cycle.
- reset acts asynchronously. Outputs reach their reset values without waiting for a clock edge. The first arbitration occurs on the first rising edge after reset deasserts.

## Test plan
- **Reset:** assert reset with random req, d → gnt=0, ack=0, q=4'h0, busy=0, last=2; deassert and hold req=0 for 5 cycles → no change.
- **Single write:** req=3'b010, d1=4'hA → gnt=3'b010 for 2 cycles, q=4'hA two edges after sampling, ack=3'b010 for exactly 1 cycle, last=1.
- **Contention:** req=3'b111 held continuously, d0=1, d1=2, d2=3 from reset → ack order 0,1,2,0; q sequence 1,2,3,1; each write 3 cycles apart.
- **Rotation:** after requester 2 writes (last=2), then req=3'b101 → requester 0 wins; next round → requester 2 wins.
- **Abandon:** req=3'b001, drop req0 during GRANT → no ack, q unchanged, last unchanged, FSM back in IDLE after 1 cycle.
- **Reset mid-op:** assert reset asynchronously during COMMIT with d2=4'hF → ack drops immediately, q=0, last=2; after release, pending req=3'b100 is granted normally.
